// File: rtl/alu4_ctrl.sv
// alu4_ctrl: command/result sequencer wrapped around an external 4-bit
// combinational ALU.
//
// A command (op, a, b, cin, chain) is accepted on the input handshake and
// latched. The ALU is then driven for exactly one EXEC cycle from those
// registers. At the end of EXEC the result and flags are captured into a
// HOLD stage that is offered on the output handshake.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_in_valid / o_in_ready   command handshake
//   i_in_op, i_in_a, i_in_b   function code and operands
//   i_in_cin                  carry-in, used by op 000 only
//   i_in_chain                1 = use the accumulator in place of i_in_a
//   o_alu_a/b/c/cin           registered drive to the ALU
//   i_alu_result/overflow/carry/size   ALU response
//   o_out_valid / i_out_ready result handshake
//   o_out_result, o_out_flags ({size, zero, overflow, carry}), o_out_op
//   o_op_cnt                  completed output handshakes, wrapping
module alu4_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_in_op,
    input  logic [3:0]       i_in_a,
    input  logic [3:0]       i_in_b,
    input  logic             i_in_cin,
    input  logic             i_in_chain,
    output logic [3:0]       o_alu_a,
    output logic [3:0]       o_alu_b,
    output logic [2:0]       o_alu_c,
    output logic             o_alu_cin,
    input  logic [3:0]       i_alu_result,
    input  logic             i_alu_overflow,
    input  logic             i_alu_carry,
    input  logic             i_alu_size,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [3:0]       o_out_result,
    output logic [3:0]       o_out_flags,
    output logic [2:0]       o_out_op,
    output logic [CNT_W-1:0] o_op_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Command registers
    logic [2:0]       r_cmd_op;
    logic [3:0]       r_cmd_a;
    logic [3:0]       r_cmd_b;
    logic             r_cmd_cin;

    // Accumulator, result stage and counter
    logic [3:0]       r_acc;
    logic [3:0]       r_out_result;
    logic [3:0]       r_out_flags;
    logic [2:0]       r_out_op;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_exec;
    logic             w_accept;
    logic             w_out_hs;
    logic             w_inv_b;
    logic             w_arith;
    logic             w_size_en;
    logic             w_zero;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_in_valid) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                w_state_next = StHold;
            end
            StHold: begin
                // Result taken: go straight back to EXEC if a new command
                // is accepted on the same edge.
                if (i_out_ready) begin
                    w_state_next = i_in_valid ? StExec : StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            StIdle: w_in_ready = i_rst_n;
            StExec: w_exec = 1'b1;
            StHold: begin
                w_out_valid = 1'b1;
                w_in_ready  = i_rst_n & i_out_ready;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = i_in_valid & w_in_ready;
    assign w_out_hs = w_out_valid & i_out_ready;

    // ---------------- op decode (from latched op only) ----------------
    // Subtract-style ops feed ~B with a forced carry-in of 1.
    assign w_inv_b   = (r_cmd_op == 3'b001) || (r_cmd_op == 3'b110) || (r_cmd_op == 3'b111);
    assign w_arith   = w_inv_b || (r_cmd_op == 3'b000);
    assign w_size_en = (r_cmd_op[2:1] == 2'b11);
    assign w_zero    = (i_alu_result == 4'd0);

    assign o_alu_a   = r_cmd_a;
    assign o_alu_b   = w_inv_b ? ~r_cmd_b : r_cmd_b;
    assign o_alu_c   = r_cmd_op;
    assign o_alu_cin = w_inv_b ? 1'b1 : ((r_cmd_op == 3'b000) ? r_cmd_cin : 1'b0);

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cmd_op     <= 3'd0;
            r_cmd_a      <= 4'd0;
            r_cmd_b      <= 4'd0;
            r_cmd_cin    <= 1'b0;
            r_acc        <= 4'd0;
            r_out_result <= 4'd0;
            r_out_flags  <= 4'd0;
            r_out_op     <= 3'd0;
            r_op_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_cmd_op  <= i_in_op;
                // Chain is resolved here so the ALU never sees i_in_* directly.
                r_cmd_a   <= i_in_chain ? r_acc : i_in_a;
                r_cmd_b   <= i_in_b;
                r_cmd_cin <= i_in_cin;
            end
            if (w_exec) begin
                r_out_result <= i_alu_result;
                r_acc        <= i_alu_result;
                r_out_op     <= r_cmd_op;
                r_out_flags  <= {w_size_en & i_alu_size, w_zero,
                                 w_arith & i_alu_overflow, w_arith & i_alu_carry};
            end
            if (w_out_hs) begin
                r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = w_out_valid;
    assign o_out_result = r_out_result;
    assign o_out_flags  = r_out_flags;
    assign o_out_op     = r_out_op;
    assign o_op_cnt     = r_op_cnt;

endmodule

// File: tb/tb_alu4_ctrl.sv
// Testbench for alu4_ctrl: behavioural ALU, directed command stream,
// queue-based scoreboard checked by an independent output monitor.
module tb_alu4_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_cin;
    logic       in_chain;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_c;
    logic       alu_cin;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic       alu_carry;
    logic       alu_size;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [2:0] out_op;
    logic [7:0] op_cnt;

    alu4_ctrl #(.CNT_W(8)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_op        (in_op),
        .i_in_a         (in_a),
        .i_in_b         (in_b),
        .i_in_cin       (in_cin),
        .i_in_chain     (in_chain),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_c        (alu_c),
        .o_alu_cin      (alu_cin),
        .i_alu_result   (alu_result),
        .i_alu_overflow (alu_overflow),
        .i_alu_carry    (alu_carry),
        .i_alu_size     (alu_size),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_result   (out_result),
        .o_out_flags    (out_flags),
        .o_out_op       (out_op),
        .o_op_cnt       (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. Logic ops drive all flags high so the DUT's masking
    // of carry/overflow/size is observable.
    logic [4:0] sum5;
    always_comb begin
        sum5         = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_result   = 4'd0;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        alu_size     = 1'b1;
        case (alu_c)
            3'b000, 3'b001, 3'b110, 3'b111: begin
                alu_result   = sum5[3:0];
                alu_carry    = sum5[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
                alu_size     = ~sum5[4];
            end
            3'b010:  alu_result = alu_a | alu_b;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = ~alu_a;
        endcase
    end

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic [2:0] op;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                m_e = q.pop_front();
                check("out_result", 32'(out_result), 32'(m_e.res));
                check("out_flags",  32'(out_flags),  32'(m_e.flags));
                check("out_op",     32'(out_op),     32'(m_e.op));
            end
        end
    end

    // Presents a command until accepted; returns at posedge+1 of the accept edge.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic chain, input logic do_push,
                        input logic [3:0] er, input logic [3:0] ef);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_chain = chain;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (do_push) begin
            e.res   = er;
            e.flags = ef;
            e.op    = op;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        in_cin    = 1'b0;
        in_chain  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_flags",  32'(out_flags),  32'd0);
        check("rst_out_op",     32'(out_op),     32'd0);
        check("rst_op_cnt",     32'(op_cnt),     32'd0);
        check("rst_alu_a",      32'(alu_a),      32'd0);
        check("rst_alu_c",      32'(alu_c),      32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 7 + 1: signed overflow, latency and op_cnt
        send(3'b000, 4'd7, 4'd1, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0010);
        check("exec_out_valid", 32'(out_valid), 32'd0);
        check("exec_in_ready",  32'(in_ready),  32'd0);
        check("add_alu_a",      32'(alu_a),     32'd7);
        check("add_alu_b",      32'(alu_b),     32'b0001);
        check("add_alu_cin",    32'(alu_cin),   32'd0);
        @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("op_cnt_1", 32'(op_cnt), 32'd1);

        // 3 - 3 with cin forced to 1 even though in_cin=0
        send(3'b001, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0101);
        check("sub_alu_b",   32'(alu_b),   32'b1100);
        check("sub_alu_cin", 32'(alu_cin), 32'd1);

        send(3'b011, 4'b1100, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0000);
        send(3'b000, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0101);
        send(3'b000, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 4'b0111, 4'b0000);
        send(3'b000, 4'hF, 4'd2, 1'b0, 1'b1, 1'b1, 4'b1001, 4'b0010);
        send(3'b100, 4'h0, 4'd0, 1'b0, 1'b1, 1'b1, 4'b1001, 4'b0000);
        send(3'b110, 4'd2, 4'd5, 1'b1, 1'b0, 1'b1, 4'b1101, 4'b1000);
        send(3'b010, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
        send(3'b111, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0101);
        drain();
        check("op_cnt_10", 32'(op_cnt), 32'd10);

        // Back-pressure with a waiting command
        out_ready = 1'b0;
        send(3'b000, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = 3'b011;
        in_a     = 4'hF;
        in_b     = 4'h3;
        in_chain = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid",  32'(out_valid),  32'd1);
            check("bp_in_ready",   32'(in_ready),   32'd0);
            check("bp_out_result", 32'(out_result), 32'd2);
            check("bp_op_cnt",     32'(op_cnt),     32'd10);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'b011, 4'hF, 4'h3, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0000);
        check("bp_exec_out_valid", 32'(out_valid), 32'd0);
        check("bp_exec_in_ready",  32'(in_ready),  32'd0);
        check("bp_op_cnt_11",      32'(op_cnt),    32'd11);
        drain();
        check("op_cnt_12", 32'(op_cnt), 32'd12);

        // Reset during EXEC discards the command
        send(3'b000, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("inrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        check("postrst_op_cnt",    32'(op_cnt),    32'd0);
        check("postrst_in_ready",  32'(in_ready),  32'd1);
        // Chained op shows acc was cleared
        send(3'b000, 4'hF, 4'd3, 1'b0, 1'b1, 1'b1, 4'b0011, 4'b0000);
        drain();
        check("final_op_cnt", 32'(op_cnt), 32'd1);
        check("queue_empty",  32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu4_ctrl.md
ALU4_CTRL -- requirements
Module: alu4_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of completed-operation counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  upstream command valid.
REQ-005 in_ready  out  1  block can accept command this cycle.
REQ-006 in_op  in  3  ALU function code 000..111.
REQ-007 in_a, in_b  in  4 each  operands.
REQ-008 in_cin  in  1  carry-in; used only for op 000.
REQ-009 in_chain  in  1  1 = replace in_a with accumulator.
REQ-010 alu_a, alu_b  out  4 each  operands driven to ALU.
REQ-011 alu_c  out  3  function select driven to ALU.
REQ-012 alu_cin  out  1  carry-in driven to ALU.
REQ-013 alu_result  in  4  ALU result, combinational from alu_* outputs.
REQ-014 alu_overflow, alu_carry, alu_size  in  1 each  ALU flags.
REQ-015 out_valid  out  1  captured result valid.
REQ-016 out_ready  in  1  downstream accepts result.
REQ-017 out_result  out  4  captured result.
REQ-018 out_flags  out  4  {size, zero, overflow, carry}.
REQ-019 out_op  out  3  op code of captured result.
REQ-020 op_cnt  out  CNT_W  count of completed output handshakes.

Function
REQ-021 FSM states IDLE, EXEC, HOLD; exactly one active.
REQ-022 in_ready = 1 in IDLE, = out_ready in HOLD, 0 in EXEC.
REQ-023 Accept = in_valid & in_ready; latch op, operands, cin, chain into command regs; next state EXEC.
REQ-024 Operand A latched = acc when in_chain=1, else in_a.
REQ-025 alu_* outputs driven only from command regs (registered, never from in_* combinationally).
REQ-026 Ops 001, 110, 111: alu_b = ~B, alu_cin = 1; in_cin ignored.
REQ-027 Op 000: alu_b = B, alu_cin = latched cin; ops 010..101: alu_b = B, alu_cin = 0.
REQ-028 EXEC lasts exactly one cycle; at its end capture alu_result into out_result and acc, op into out_op; next state HOLD.
REQ-029 zero flag computed locally: 1 iff alu_result == 0, for every op.
REQ-030 carry, overflow captured from ALU for ops 000, 001, 110, 111; forced 0 otherwise.
REQ-031 size captured from alu_size for ops 110, 111; forced 0 otherwise.
REQ-032 out_valid = 1 exactly in HOLD; out_* stable while out_valid & ~out_ready.
REQ-033 Output handshake = out_valid & out_ready: op_cnt += 1 (wraps at 2^CNT_W); next state EXEC if accept same cycle, else IDLE.
REQ-034 Latency: out_valid asserted 2 cycles after accept edge; max throughput 1 op per 2 cycles.
REQ-035 in_valid during EXEC or blocked HOLD is ignored (not latched); upstream must hold it.

Reset
REQ-036 rst_n=0 at a clock edge: state IDLE, out_valid 0, out_result 0, out_flags 0, out_op 0, acc 0, op_cnt 0, command regs 0.
REQ-037 Reset in EXEC or HOLD discards pending command and result; no handshake counted.
REQ-038 in_ready = 0 while rst_n = 0.

Verification
REQ-039 Op 000, a=7, b=1, cin=0, out_ready=1 -> alu_b=0001, out_result=1000, flags {0,0,1,0}, out_valid 2 cycles after accept, op_cnt=1.
REQ-040 Op 001, a=3, b=3 -> alu_b=1100, alu_cin=1, out_result=0000, zero=1, carry=1, overflow=0.
REQ-041 Op 011, a=1100, b=1010 -> out_result=1000, carry=0, overflow=0, size=0, zero=0.
REQ-042 Op 000 3+4 then chained op 000 b=2 (in_a=15 ignored) -> second out_result=1001, acc=1001.
REQ-043 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> out_* unchanged, in_ready=0, op_cnt unchanged; out_ready=1 -> handshake plus accept same cycle, EXEC next.
REQ-044 rst_n=0 one cycle during EXEC -> next cycle out_valid=0, op_cnt=0, acc=0, state IDLE, in_ready=1.
